torus_inject_arbiter: RTL and testbench

- Shares the single client injection port (i_v/i_x/i_y/i_data/i_ack) of one torus switch node between N_REQ local requesters, such as per-VC or per-engine packet sources.
- Each requester gets a one-entry holding register.
- A round-robin scheduler offers held packets to the switch one at a time.
- The block also reports starvation (switch not accepting) and keeps a running count of injected packets.

---
 rtl/torus_inject_arbiter.sv | 136 +++++++++++++
 tb/tb_torus_inject_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/torus_inject_arbiter.sv
// Round-robin injection arbiter: N_REQ one-entry holding slots share one torus switch
// client port, with starvation flag and a running injected-packet count.
module torus_inject_arbiter #(
   parameter int X_W        = 2,
   parameter int Y_W        = 2,
   parameter int D_W        = 32,
   parameter int N_REQ      = 4,
   parameter int STARVE_MAX = 15,
   parameter int CNT_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_v,
   input  logic [N_REQ*X_W-1:0]       req_x,
   input  logic [N_REQ*Y_W-1:0]       req_y,
   input  logic [N_REQ*D_W-1:0]       req_data,
   output logic [N_REQ-1:0]           req_rdy,
   output logic                       i_v,
   output logic [X_W-1:0]             i_x,
   output logic [Y_W-1:0]             i_y,
   output logic [D_W-1:0]             i_data,
   input  logic                       i_ack,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       starve,
   output logic [CNT_W-1:0]           inj_count
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int SC_W  = $clog2(STARVE_MAX + 1);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t               state_q;
   logic [N_REQ-1:0]     hold_v_q;
   logic [X_W-1:0]       hold_x_q    [N_REQ];
   logic [Y_W-1:0]       hold_y_q    [N_REQ];
   logic [D_W-1:0]       hold_data_q [N_REQ];
   logic [IDX_W-1:0]     ptr_q, cur_q, cur_inc;
   logic [SC_W-1:0]      starve_cnt_q;
   logic [CNT_W-1:0]     inj_count_q;
   logic                 offer, drain;
   logic [IDX_W:0]       pick_idle, pick_ack;
   logic [N_REQ-1:0]     ack_mask;

   // Returns {found, index} of the first set mask bit scanning start, start+1, ... with wrap.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                              input logic [IDX_W-1:0] start);
      logic [IDX_W:0] res;
      int j;
      res = '0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(start) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (!res[IDX_W] && mask[j]) res = {1'b1, IDX_W'(j)};
      end
      return res;
   endfunction

   assign offer    = (state_q == OFFER);
   assign drain    = offer & i_ack;
   assign cur_inc  = (cur_q == IDX_W'(N_REQ - 1)) ? '0 : cur_q + 1'b1;
   assign ack_mask = hold_v_q & ~(N_REQ'(1) << cur_q);
   assign pick_idle = rr_pick(hold_v_q, ptr_q);
   assign pick_ack  = rr_pick(ack_mask, cur_inc);

   assign i_v       = offer;
   assign i_x       = offer ? hold_x_q[cur_q]    : '0;
   assign i_y       = offer ? hold_y_q[cur_q]    : '0;
   assign i_data    = offer ? hold_data_q[cur_q] : '0;
   assign grant_id  = cur_q;
   assign starve    = (starve_cnt_q == SC_W'(STARVE_MAX));
   assign inj_count = inj_count_q;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_slot
         logic drain_k, load_k;
         assign drain_k     = drain & (cur_q == IDX_W'(gi));
         assign req_rdy[gi] = ~hold_v_q[gi] | drain_k;
         assign load_k      = req_v[gi] & req_rdy[gi];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               hold_v_q[gi] <= 1'b0;
            end else if (load_k) begin
               hold_v_q[gi] <= 1'b1;
            end else if (drain_k) begin
               hold_v_q[gi] <= 1'b0;
            end
         end

         // Payload needs no reset: it is only visible while its valid bit is set.
         always_ff @(posedge clk) begin
            if (load_k) begin
               hold_x_q[gi]    <= req_x[gi*X_W +: X_W];
               hold_y_q[gi]    <= req_y[gi*Y_W +: Y_W];
               hold_data_q[gi] <= req_data[gi*D_W +: D_W];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         cur_q        <= '0;
         starve_cnt_q <= '0;
         inj_count_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               starve_cnt_q <= '0;
               if (pick_idle[IDX_W]) begin
                  cur_q   <= pick_idle[IDX_W-1:0];
                  state_q <= OFFER;
               end
            end
            OFFER: begin
               if (i_ack) begin
                  inj_count_q  <= inj_count_q + 1'b1;
                  ptr_q        <= cur_inc;
                  starve_cnt_q <= '0;
                  // The just-drained slot is masked, so a same-cycle refill waits its turn.
                  if (pick_ack[IDX_W]) cur_q <= pick_ack[IDX_W-1:0];
                  else                 state_q <= IDLE;
               end else if (!starve) begin
                  starve_cnt_q <= starve_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_torus_inject_arbiter.sv
// Directed-vector bench for torus_inject_arbiter with hand-computed expectations.
module tb_torus_inject_arbiter;

   localparam int X_W = 2, Y_W = 2, D_W = 32, N_REQ = 4, STARVE_MAX = 15, CNT_W = 16;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [N_REQ-1:0]      req_v = '0;
   logic [N_REQ*X_W-1:0]  req_x = '0;
   logic [N_REQ*Y_W-1:0]  req_y = '0;
   logic [N_REQ*D_W-1:0]  req_data = '0;
   logic [N_REQ-1:0]      req_rdy;
   logic                  i_v;
   logic [X_W-1:0]        i_x;
   logic [Y_W-1:0]        i_y;
   logic [D_W-1:0]        i_data;
   logic                  i_ack = 1'b0;
   logic [1:0]            grant_id;
   logic                  starve;
   logic [CNT_W-1:0]      inj_count;

   int vec_cnt = 0;
   int err_cnt = 0;

   torus_inject_arbiter #(
      .X_W(X_W), .Y_W(Y_W), .D_W(D_W), .N_REQ(N_REQ),
      .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .req_v(req_v), .req_x(req_x), .req_y(req_y), .req_data(req_data),
      .req_rdy(req_rdy),
      .i_v(i_v), .i_x(i_x), .i_y(i_y), .i_data(i_data), .i_ack(i_ack),
      .grant_id(grant_id), .starve(starve), .inj_count(inj_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int k, input logic [1:0] x, input logic [1:0] y, input logic [31:0] d);
      req_v[k] = 1'b1;
      req_x[k*X_W +: X_W] = x;
      req_y[k*Y_W +: Y_W] = y;
      req_data[k*D_W +: D_W] = d;
   endtask

   task automatic do_reset();
      req_v = '0;
      i_ack = 1'b0;
      #2 rst = 1'b0;
      tick();
      #2 rst = 1'b1;
      tick();
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst_i_v", i_v, 0);
      chk("rst_req_rdy", req_rdy, 4'b1111);
      chk("rst_grant", grant_id, 0);
      chk("rst_starve", starve, 0);
      chk("rst_inj", inj_count, 0);
      chk("rst_i_data", i_data, 0);
      #4 rst = 1'b1;
      tick();

      // Single requester 2, ack tied high
      i_ack = 1'b1;
      load(2, 2'd1, 2'd2, 32'hA5);
      tick();
      req_v = '0;
      chk("t1_idle_after_load", i_v, 0);
      tick();
      chk("t1_i_v", i_v, 1);
      chk("t1_x", i_x, 1);
      chk("t1_y", i_y, 2);
      chk("t1_data", i_data, 32'hA5);
      chk("t1_grant", grant_id, 2);
      tick();
      chk("t1_one_cycle", i_v, 0);
      chk("t1_inj", inj_count, 1);
      tick();
      chk("t1_ack_ignored_idle", inj_count, 1);

      // All four at once, back-to-back grants
      do_reset();
      for (int k = 0; k < N_REQ; k++) load(k, 2'(k), 2'(3 - k), 32'h100 + k);
      i_ack = 1'b1;
      tick();
      req_v = '0;
      tick();
      for (int k = 0; k < N_REQ; k++) begin
         chk($sformatf("t2_iv_%0d", k), i_v, 1);
         chk($sformatf("t2_grant_%0d", k), grant_id, k);
         chk($sformatf("t2_data_%0d", k), i_data, 32'h100 + k);
         tick();
      end
      chk("t2_idle", i_v, 0);
      chk("t2_inj", inj_count, 4);
      // ptr back at 0: with 1 and 3 held, 1 is found first
      load(1, 0, 0, 32'h11);
      load(3, 0, 0, 32'h33);
      tick();
      req_v = '0;
      tick();
      chk("t2_ptr_wrap", grant_id, 1);

      // Starvation on requester 1
      do_reset();
      load(1, 2'd3, 2'd1, 32'hDEAD_BEEF);
      tick();
      req_v = '0;
      tick();
      chk("t3_offer", i_v, 1);
      chk("t3_grant", grant_id, 1);
      chk("t3_starve0", starve, 0);
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 14) chk("t3_starve_14", starve, 0);
         if (k == 15) chk("t3_starve_15", starve, 1);
         if (k == 20) begin
            chk("t3_starve_20", starve, 1);
            chk("t3_data_stable", i_data, 32'hDEAD_BEEF);
            chk("t3_x_stable", i_x, 3);
            chk("t3_grant_stable", grant_id, 1);
         end
      end
      i_ack = 1'b1;
      tick();
      i_ack = 1'b0;
      chk("t3_starve_clr", starve, 0);
      chk("t3_inj", inj_count, 1);
      chk("t3_idle", i_v, 0);

      // Refill of slot 0 on its ack cycle
      do_reset();
      load(0, 0, 0, 32'hAAAA);
      load(1, 1, 1, 32'hBBBB);
      tick();
      req_v = '0;
      tick();
      chk("t4_grant0", grant_id, 0);
      i_ack = 1'b1;
      load(0, 2, 2, 32'hCCCC);
      #1;
      chk("t4_rdy0_ack", req_rdy[0], 1);
      chk("t4_rdy1_held", req_rdy[1], 0);
      tick();
      req_v = '0;
      chk("t4_grant1", grant_id, 1);
      chk("t4_data1", i_data, 32'hBBBB);
      tick();
      chk("t4_grant0_again", grant_id, 0);
      chk("t4_data0_new", i_data, 32'hCCCC);
      tick();
      chk("t4_idle", i_v, 0);
      chk("t4_inj", inj_count, 3);

      // Asynchronous reset mid-offer
      do_reset();
      load(3, 1, 1, 32'h3333);
      tick();
      req_v = '0;
      tick();
      chk("t5_offer3", grant_id, 3);
      i_ack = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("t5_async_iv", i_v, 0);
      chk("t5_async_rdy", req_rdy, 4'b1111);
      tick();
      chk("t5_no_ack_in_rst", inj_count, 0);
      #2 rst = 1'b1;
      i_ack = 1'b0;
      tick();
      tick();
      chk("t5_no_offer", i_v, 0);
      chk("t5_rdy_after", req_rdy, 4'b1111);

      // Requesters 0 and 2 refill continuously: strict alternation
      do_reset();
      load(0, 0, 0, 32'h0);
      load(2, 2, 2, 32'h2);
      i_ack = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("t6_grant_%0d", k), grant_id, (k % 2 == 0) ? 0 : 2);
         tick();
      end
      req_v = '0;
      chk("t6_inj", inj_count, 6);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
